// File: rtl/l1_data_array_assoc.sv
// Set-associative L1 data array: word read/byte-masked store in IDLE, beat-wise line refill in FILL.
// Optional macro L1_DATA_FWD_EN forwards a same-cycle store into the read result.
module l1_data_array_assoc #(
  parameter int SETS      = 64,
  parameter int WAYS      = 2,
  parameter int LINE_BITS = 512,
  parameter int WORD_BITS = 32,
  parameter int BEAT_BITS = 128
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic [$clog2(SETS)-1:0]        index,
  input  logic [$clog2(WAYS)-1:0]        way,
  input  logic [$clog2(LINE_BITS/8)-1:0] offset,
  input  logic                           rd_en,
  output logic [WORD_BITS-1:0]           rd_data,
  output logic                           rd_valid,
  input  logic                           wr_en,
  input  logic [WORD_BITS/8-1:0]         wr_be,
  input  logic [WORD_BITS-1:0]           wr_data,
  input  logic                           refill_start,
  input  logic                           beat_valid,
  output logic                           beat_ready,
  input  logic [BEAT_BITS-1:0]           beat_data,
  output logic                           refill_busy,
  output logic                           refill_done,
  output logic                           dbg_state_o
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int OFF_W  = $clog2(LINE_BITS/8);
  localparam int BE_W   = WORD_BITS/8;
  localparam int BSEL_W = $clog2(BE_W);
  localparam int WSEL_W = OFF_W - BSEL_W;
  localparam int LINES  = SETS*WAYS;
  localparam int LINE_W = IDX_W + WAY_W;
  localparam int BEATS  = LINE_BITS/BEAT_BITS;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS-1);

  typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]   fill_line_q, fill_line_d;

  logic                beat_ready_d, refill_busy_d;
  logic                fill_we, acc_rd, acc_wr;

  logic [WORD_BITS-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, refill_done_q;

  logic [LINE_BITS-1:0] lines [LINES];
  logic [LINE_W-1:0]    line_addr;
  logic [WSEL_W-1:0]    word_sel;
  logic [LINE_BITS-1:0] cur_line;
  logic [WORD_BITS-1:0] old_word, wr_merged;
  logic                 offset_unused;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      fill_line_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_line_q <= fill_line_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_line_d = fill_line_q;
    case (state_q)
      S_IDLE: begin
        if (refill_start) begin
          state_d     = S_FILL;
          cnt_d       = '0;
          fill_line_d = {index, way};
        end
      end
      S_FILL: begin
        if (beat_valid) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // refill_start wins over rd/wr in the same IDLE cycle; FILL ignores them entirely.
  always_comb begin
    beat_ready_d  = 1'b0;
    refill_busy_d = 1'b0;
    fill_we       = 1'b0;
    acc_rd        = 1'b0;
    acc_wr        = 1'b0;
    case (state_q)
      S_IDLE: begin
        acc_rd = rd_en & ~refill_start;
        acc_wr = wr_en & ~refill_start;
      end
      S_FILL: begin
        beat_ready_d  = 1'b1;
        refill_busy_d = 1'b1;
        fill_we       = beat_valid;
      end
      default: ;
    endcase
  end

  assign beat_ready  = beat_ready_d;
  assign refill_busy = refill_busy_d;
  assign dbg_state_o = (state_q == S_FILL);

  // ---------------- datapath ----------------
  assign line_addr     = {index, way};
  assign word_sel      = offset[OFF_W-1:BSEL_W];
  assign offset_unused = ^offset[BSEL_W-1:0];
  assign cur_line      = lines[line_addr];
  assign old_word      = cur_line[word_sel*WORD_BITS +: WORD_BITS];

  always_comb begin
    wr_merged = old_word;
    for (int k = 0; k < BE_W; k++) begin
      if (wr_be[k]) wr_merged[8*k +: 8] = wr_data[8*k +: 8];
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (acc_rd) begin
`ifdef L1_DATA_FWD_EN
      rd_data_d = acc_wr ? wr_merged : old_word;
`else
      rd_data_d = old_word;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      refill_done_q <= 1'b0;
    end else begin
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= acc_rd;
      refill_done_q <= fill_we && (cnt_q == CNT_LAST);
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign refill_done = refill_done_q;

  // One register per line so reset can clear the whole array in a single cycle.
  for (genvar g = 0; g < LINES; g++) begin : g_line
    logic [LINE_BITS-1:0] line_q;
    always_ff @(posedge clk) begin
      if (!nrst) begin
        line_q <= '0;
      end else if (fill_we && (fill_line_q == LINE_W'(g))) begin
        line_q[cnt_q*BEAT_BITS +: BEAT_BITS] <= beat_data;
      end else if (acc_wr && (line_addr == LINE_W'(g))) begin
        line_q[word_sel*WORD_BITS +: WORD_BITS] <= wr_merged;
      end
    end
    assign lines[g] = line_q;
  end

endmodule

// File: tb/tb_l1_data_array_assoc.sv
// Self-checking bench for l1_data_array_assoc: directed scenarios plus randomized traffic
// compared every cycle against a line-level behavioural model.
module tb_l1_data_array_assoc;

  localparam int SETS      = 64;
  localparam int WAYS      = 2;
  localparam int LINE_BITS = 512;
  localparam int WORD_BITS = 32;
  localparam int BEAT_BITS = 128;
  localparam int BEATS     = LINE_BITS/BEAT_BITS;
  localparam int LINES     = SETS*WAYS;
`ifdef L1_DATA_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 nrst = 1'b0;
  logic [5:0]           index = '0;
  logic [0:0]           way = '0;
  logic [5:0]           offset = '0;
  logic                 rd_en = 1'b0;
  logic [31:0]          rd_data;
  logic                 rd_valid;
  logic                 wr_en = 1'b0;
  logic [3:0]           wr_be = '0;
  logic [31:0]          wr_data = '0;
  logic                 refill_start = 1'b0;
  logic                 beat_valid = 1'b0;
  logic                 beat_ready;
  logic [127:0]         beat_data = '0;
  logic                 refill_busy;
  logic                 refill_done;
  logic                 dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;

  l1_data_array_assoc #(
    .SETS(SETS), .WAYS(WAYS), .LINE_BITS(LINE_BITS),
    .WORD_BITS(WORD_BITS), .BEAT_BITS(BEAT_BITS)
  ) dut (
    .clk(clk), .nrst(nrst), .index(index), .way(way), .offset(offset),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_be(wr_be), .wr_data(wr_data),
    .refill_start(refill_start), .beat_valid(beat_valid), .beat_ready(beat_ready),
    .beat_data(beat_data), .refill_busy(refill_busy), .refill_done(refill_done),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [LINE_BITS-1:0] m_mem [LINES];
  logic [WORD_BITS-1:0] exp_q [$];
  bit                   m_fill = 0;
  int                   m_line = 0;
  int                   m_cnt = 0;
  bit                   m_done = 0;
  bit                   m_valid = 0;
  logic [31:0]          m_rd_data = '0;

  initial begin : model
    int l, w;
    logic [31:0] old_w, new_w;
    forever begin
      @(posedge clk);
      if (!nrst) begin
        for (int i = 0; i < LINES; i++) m_mem[i] = '0;
        m_fill = 0; m_cnt = 0; m_done = 0; m_valid = 0; m_rd_data = '0;
      end else begin
        m_done = 0;
        m_valid = 0;
        if (m_fill) begin
          if (beat_valid) begin
            m_mem[m_line][m_cnt*BEAT_BITS +: BEAT_BITS] = beat_data;
            m_cnt++;
            if (m_cnt == BEATS) begin
              m_fill = 0; m_cnt = 0; m_done = 1;
            end
          end
        end else if (refill_start) begin
          m_fill = 1;
          m_line = int'(index)*WAYS + int'(way);
          m_cnt  = 0;
        end else begin
          l = int'(index)*WAYS + int'(way);
          w = int'(offset) / 4;
          old_w = m_mem[l][w*32 +: 32];
          new_w = old_w;
          for (int k = 0; k < 4; k++) if (wr_be[k]) new_w[8*k +: 8] = wr_data[8*k +: 8];
          if (rd_en) begin
            m_valid   = 1;
            m_rd_data = (FWD && wr_en) ? new_w : old_w;
            exp_q.push_back(m_rd_data);
          end
          if (wr_en) m_mem[l][w*32 +: 32] = new_w;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  initial begin : compare
    logic [31:0] e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_valid});
      chk("refill_busy", {31'd0, refill_busy}, {31'd0, m_fill});
      chk("beat_ready", {31'd0, beat_ready}, {31'd0, m_fill});
      chk("refill_done", {31'd0, refill_done}, {31'd0, m_done});
      chk("dbg_state", {31'd0, dbg_state_o}, {31'd0, m_fill});
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL exp_q_empty: got read with no expected entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e);
        end
      end else begin
        chk("rd_data_hold", rd_data, m_rd_data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_read(input int idx, input int w, input int off, output logic [31:0] d);
    index = 6'(idx); way = 1'(w); offset = 6'(off); rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    d = rd_data;
  endtask

  task automatic do_write(input int idx, input int w, input int off,
                          input logic [3:0] be, input logic [31:0] data);
    index = 6'(idx); way = 1'(w); offset = 6'(off);
    wr_en = 1'b1; wr_be = be; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Beat b carries four copies of b*0x11111111; abort_at asserts reset instead of beat abort_at.
  task automatic do_refill(input int idx, input int w, input int gap,
                           input bit noise, input int abort_at);
    logic [31:0] bw;
    index = 6'(idx); way = 1'(w); refill_start = 1'b1;
    @(negedge clk);
    refill_start = 1'b0;
    if (noise) begin
      index = 6'd3; way = 1'b0; offset = 6'h08;
      rd_en = 1'b1; wr_en = 1'b1; wr_be = 4'hF; wr_data = 32'hFFFFFFFF;
    end
    for (int b = 0; b < BEATS; b++) begin
      bw = 32'h11111111 * b;
      if (b == abort_at) begin
        nrst = 1'b0; beat_valid = 1'b1; beat_data = {4{bw}};
        @(negedge clk);
        nrst = 1'b1; beat_valid = 1'b0;
        chk("abort_busy", {31'd0, refill_busy}, 32'd0);
        chk("abort_done", {31'd0, refill_done}, 32'd0);
        return;
      end
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          beat_valid = 1'b0;
          @(negedge clk);
          chk("gap_busy", {31'd0, refill_busy}, 32'd1);
        end
      end
      beat_valid = 1'b1; beat_data = {4{bw}};
      @(negedge clk);
    end
    beat_valid = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    chk("refill_done_pulse", {31'd0, refill_done}, 32'd1);
    chk("refill_busy_after", {31'd0, refill_busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] d;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_busy", {31'd0, refill_busy}, 32'd0);
    chk("reset_ready", {31'd0, beat_ready}, 32'd0);

    // back-to-back refill of [5][1], then read word at 0x10 (beat 1)
    do_refill(5, 1, 0, 1'b0, -1);
    do_read(5, 1, 6'h10, d);
    chk("refill_read_0x10", d, 32'h11111111);
    chk("refill_read_valid", {31'd0, rd_valid}, 32'd1);

    // byte-masked store
    do_write(5, 1, 0, 4'hF, 32'hAABBCCDD);
    do_write(5, 1, 0, 4'b0101, 32'h11223344);
    do_write(5, 1, 0, 4'b0000, 32'h99999999);
    do_read(5, 1, 0, d);
    chk("byte_mask_merge", d, 32'hAABBCCDD & 32'hFF00FF00 | 32'h00220044);

    // same-cycle read and write to a zero word
    index = 6'd2; way = 1'b0; offset = 6'h00;
    rd_en = 1'b1; wr_en = 1'b1; wr_be = 4'hF; wr_data = 32'hDEADBEEF;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    chk("rd_wr_same_word", rd_data, FWD ? 32'hDEADBEEF : 32'h0);
    do_read(2, 0, 0, d);
    chk("rd_after_wr", d, 32'hDEADBEEF);

    // refill with two-cycle gaps gives the same line
    do_refill(7, 0, 2, 1'b0, -1);
    do_read(7, 0, 6'h10, d);
    chk("gap_read_0x10", d, 32'h11111111);
    do_read(7, 0, 6'h30, d);
    chk("gap_read_0x30", d, 32'h33333333);

    // rd/wr during FILL are ignored
    do_write(3, 0, 6'h08, 4'hF, 32'h12345678);
    do_refill(6, 1, 1, 1'b1, -1);
    do_read(3, 0, 6'h08, d);
    chk("fill_ignores_wr", d, 32'h12345678);

    // reset after beat 2 of a refill
    do_refill(9, 1, 0, 1'b0, 3);
    @(negedge clk);
    chk("no_done_after_abort", {31'd0, refill_done}, 32'd0);
    do_read(9, 1, 0, d);
    chk("aborted_line_zero", d, 32'h0);
    do_read(5, 1, 6'h10, d);
    chk("array_cleared", d, 32'h0);

    // randomized traffic on a few sets to force collisions
    for (int c = 0; c < 3000; c++) begin
      nrst         = ($urandom_range(0, 299) != 0);
      refill_start = ($urandom_range(0, 15) == 0);
      rd_en        = 1'($urandom_range(0, 1));
      wr_en        = 1'($urandom_range(0, 1));
      wr_be        = 4'($urandom_range(0, 15));
      wr_data      = $urandom();
      index        = 6'($urandom_range(0, 3));
      way          = 1'($urandom_range(0, 1));
      offset       = 6'($urandom_range(0, 63));
      beat_valid   = ($urandom_range(0, 2) != 0);
      beat_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
    end
    nrst = 1'b1; refill_start = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    beat_valid = 1'b1;
    repeat (BEATS + 1) @(negedge clk);
    beat_valid = 1'b0;
    @(negedge clk);

    // readback of every word touched by the random phase
    for (int i = 0; i < 4; i++)
      for (int w = 0; w < WAYS; w++)
        for (int o = 0; o < 64; o += 4)
          do_read(i, w, o, d);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
